// File: rtl/uart_program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_program_loader_pkg
//  Description : Shared constants, types and helpers for the UART program
//                loader: bit-period computation, halt word default and the
//                receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_program_loader_pkg;

    // Word that terminates a program download; it is never written to memory.
    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

    // Receiver states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // System clocks per UART bit, truncating division (868 at 100 MHz / 115200).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage : uart_program_loader_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART receiver. Two-flop synchronizer on the serial input,
//                falling-edge start detection, mid-bit sampling and stop-bit
//                checking. Emits a one-cycle rx_valid with rx_byte, or a
//                one-cycle frame_err when the stop bit reads low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMER_W      = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TIMER_W-1:0] C_HALF_LAST = TIMER_W'(HALF_BIT - 1);
    localparam logic [TIMER_W-1:0] C_FULL_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_d;
    rx_state_t          r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_valid;
    logic               r_frame_err;

    // Bring the asynchronous line into the clock domain; keep one extra
    // delayed copy so a 1->0 transition can be seen. Idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rxd;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Receiver FSM: start detect, mid-bit sampling, stop check. The edge
    // detector needs a high-to-low transition, so after a framing error the
    // FSM naturally stays idle until the line has returned high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RX_IDLE;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_sync_d && !r_sync2) begin
                        r_state <= RX_START;
                        r_timer <= '0;
                    end
                end
                RX_START: begin
                    if (r_timer == C_HALF_LAST) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_timer == C_FULL_LAST) begin
                        r_timer <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_timer == C_FULL_LAST) begin
                        r_timer <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            r_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte   = r_shift;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_program_loader
//  Description : Receives a program over UART, pairs bytes (high then low)
//                into 16-bit instructions and writes them sequentially into
//                instruction memory. Raises a sticky load_done on a halt word
//                or after the last memory location is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          BAUD      = 115200,
    parameter int          ADDR_W    = 5,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              CLK,
    input  logic              CPU_RESETN,
    input  logic              UART_TXD_IN,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              load_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    logic [7:0]        w_rx_byte;
    logic              w_rx_valid;
    logic              w_frame_err;
    logic [15:0]       w_word;

    logic              r_phase_low;   // 0: next byte is the high byte
    logic [7:0]        r_high_byte;
    logic [ADDR_W-1:0] r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_load_done;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk       (CLK),
        .rst_n     (CPU_RESETN),
        .rxd       (UART_TXD_IN),
        .rx_byte   (w_rx_byte),
        .rx_valid  (w_rx_valid),
        .frame_err (w_frame_err)
    );

    assign w_word = {r_high_byte, w_rx_byte};

    // Word assembly, write strobe generation, address counting and load_done.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_phase_low <= 1'b0;
            r_high_byte <= '0;
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;

            if (w_frame_err) begin
                // A bad frame drops any half-assembled word.
                r_phase_low <= 1'b0;
            end else if (w_rx_valid) begin
                if (!r_phase_low) begin
                    r_high_byte <= w_rx_byte;
                    r_phase_low <= 1'b1;
                end else begin
                    r_phase_low <= 1'b0;
                    if (!r_load_done) begin
                        if (w_word != HALT_WORD) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_count;
                            r_wr_data <= w_word;
                        end else begin
                            r_load_done <= 1'b1;
                        end
                    end
                end
            end

            // Advance the address after each write; the final location ends
            // the load instead of wrapping back to zero.
            if (r_wr_en) begin
                if (r_wr_addr == C_LAST_ADDR) begin
                    r_load_done <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign load_done = r_load_done;
    assign frame_err = w_frame_err;

endmodule : uart_program_loader
`default_nettype wire
